tia_gain_controller: RTL and testbench
======================================

TIA_GAIN_CONTROLLER -- requirements
Module: tia_gain_controller

Interface
REQ-001 SHALL have parameter HI_THRESH, default 16'd4300: sample code (mV) at or above which a sample counts as near-saturation.
REQ-002 SHALL have parameter LO_THRESH, default 16'd400: averaged code (mV) below which gain is stepped up.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16, legal range 1..255: clk cycles of settling blanking after any gain change.
REQ-004 SHALL have parameter AVG_LOG2, default 2, legal range 0..4: each result averages 2^AVG_LOG2 samples.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: run auto-ranging while high.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample is valid this cycle.
REQ-009 SHALL have port sample, input, 16 bits: amplifier output code in mV, unsigned.
REQ-010 SHALL have port gain_sel, output, 2 bits: feedback-resistor select (0=10k, 1=100k, 2=1M, 3=10M).
REQ-011 SHALL have port settling, output, 1 bit: high while in SETTLE.
REQ-012 SHALL have port result_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-013 SHALL have port result_code, output, 16 bits: averaged sample code.
REQ-014 SHALL have port result_range, output, 2 bits: gain_sel in force while the result was accumulated.
REQ-015 SHALL have port sat_flag, output, 1 bit: result contains at least one sample >= HI_THRESH taken at gain_sel=0.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, ACCUM, EVAL.
REQ-017 IDLE: on enable=1, SHALL enter SETTLE and load the settle counter with SETTLE_CYCLES.
REQ-018 SETTLE: SHALL ignore samples and decrement the counter once per cycle; when it reaches 0, SHALL enter ACCUM with the accumulator, sample count and sat capture cleared.
REQ-019 ACCUM: each sample_valid cycle SHALL add sample to a (16+AVG_LOG2)-bit accumulator and increment the sample count; the accumulator SHALL never overflow.
REQ-020 ACCUM: a valid sample >= HI_THRESH with gain_sel>0 SHALL decrement gain_sel in the same cycle and enter SETTLE, discarding the partial accumulation.
REQ-021 ACCUM: a valid sample >= HI_THRESH with gain_sel=0 SHALL be accumulated and SHALL set the sat capture.
REQ-022 ACCUM: the cycle the 2^AVG_LOG2-th sample is accepted, SHALL enter EVAL.
REQ-023 EVAL (one cycle): avg = accumulator >> AVG_LOG2, truncating; if avg < LO_THRESH and gain_sel<3, SHALL increment gain_sel and enter SETTLE with no result.
REQ-024 EVAL otherwise: SHALL pulse result_valid for exactly that cycle with result_code=avg, result_range=gain_sel and sat_flag=sat capture, then re-enter ACCUM with the accumulator cleared.
REQ-025 result_code, result_range and sat_flag SHALL hold their values until the next result.
REQ-026 A result SHALL appear no earlier than 1 cycle after the last sample of the block.
REQ-027 enable=0 in any state SHALL return the FSM to IDLE on the next edge, discard partial data, produce no result and hold gain_sel.
REQ-028 At most one gain step SHALL occur per settle period; gain_sel SHALL saturate at 0 and 3 and never wrap.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, gain_sel=0, settling=0, result_valid=0, result_code=0, result_range=0, sat_flag=0, and clear the counter and accumulator.
REQ-030 Reset mid-operation SHALL abandon the operation with no result pulse; operation SHALL resume from IDLE on the first edge after rst falls.

Structure
REQ-031 Package tia_ctrl_pkg SHALL hold the state enumeration, the gain code constants GAIN_10K..GAIN_10M, and the resistor value table indexed by gain code.
REQ-032 Accumulate/average logic SHALL be the sub-module tia_sample_averager (inputs clear, add, sample; outputs avg, count_done); the FSM, gain control and settle counter SHALL stay in the top module.

Verification
REQ-033 Reset, enable=1, constant sample=2000 valid every cycle -> settling high for 16 cycles, then result_valid pulses every 5 cycles with result_code=2000, range=0, sat_flag=0.
REQ-034 sample=100 constant -> gain steps 0->1->2->3, each step followed by 16 settle cycles; final results report range=3 with code 100.
REQ-035 At gain 2, a single sample=4400 mid-block -> gain_sel=1 that cycle, settling asserted, no result pulse for the discarded block.
REQ-036 gain_sel=0 with samples 4500,4500,1000,1000 -> result_code=2750, sat_flag=1, gain_sel stays 0.
REQ-037 enable dropped in ACCUM after 2 samples, then raised again -> no result, FSM in IDLE, gain held; next result only after a full settle period.
REQ-038 rst asserted during SETTLE at gain 3 -> outputs at reset values asynchronously, gain_sel=0.

Source files
------------

// File: rtl/tia_ctrl_pkg.sv
// Shared types and constants for the transimpedance-amplifier gain controller.
package tia_ctrl_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned GAIN_W   = 2;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_EVAL   = 2'd3
  } state_t;

  localparam logic [GAIN_W-1:0] GAIN_10K  = 2'd0;
  localparam logic [GAIN_W-1:0] GAIN_100K = 2'd1;
  localparam logic [GAIN_W-1:0] GAIN_1M   = 2'd2;
  localparam logic [GAIN_W-1:0] GAIN_10M  = 2'd3;

  // Feedback resistor in ohms, indexed by gain code.
  localparam int unsigned RES_OHMS [4] = '{32'd10000, 32'd100000, 32'd1000000, 32'd10000000};

  function automatic int unsigned res_ohms(input logic [GAIN_W-1:0] gain);
    return RES_OHMS[gain];
  endfunction

endpackage

// File: rtl/tia_sample_averager.sv
// Block accumulator: sums 2^AVG_LOG2 samples and exposes the truncated mean.
module tia_sample_averager
  import tia_ctrl_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                add,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg,
  output logic                count_done
);

  // Sum of 2^AVG_LOG2 16-bit codes always fits in 16+AVG_LOG2 bits.
  localparam int unsigned ACC_W  = SAMPLE_W + AVG_LOG2;
  localparam int unsigned CNTA_W = AVG_LOG2 + 1;
  localparam int unsigned N_SAMP = 1 << AVG_LOG2;

  logic [ACC_W-1:0]  acc_q;
  logic [CNTA_W-1:0] count_q;

  // Accumulator and sample counter; clear wins over add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (add) begin
      acc_q   <= acc_q + ACC_W'(sample);
      count_q <= count_q + CNTA_W'(1);
    end
  end

  assign count_done = add && !clear && (count_q == CNTA_W'(N_SAMP - 1));
  assign avg        = SAMPLE_W'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/tia_gain_controller.sv
// Auto-ranging gain controller: settles, averages blocks of samples and steps
// the TIA feedback resistor up on weak signal or down on near-saturation.
module tia_gain_controller
  import tia_ctrl_pkg::*;
#(
  parameter logic [15:0] HI_THRESH     = 16'd4300,
  parameter logic [15:0] LO_THRESH     = 16'd400,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic [1:0]  gain_sel,
  output logic        settling,
  output logic        result_valid,
  output logic [15:0] result_code,
  output logic [1:0]  result_range,
  output logic        sat_flag
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t              state_q;
  logic [GAIN_W-1:0]   gain_q;
  logic [CNT_W-1:0]    settle_cnt_q;
  logic                sat_q;
  logic                settling_q;
  logic                result_valid_q;
  logic [SAMPLE_W-1:0] result_code_q;
  logic [GAIN_W-1:0]   result_range_q;
  logic                sat_flag_q;

  logic                hi_c;
  logic                step_down_c;
  logic                avg_clear_c;
  logic                avg_add_c;
  logic                avg_done_c;
  logic [SAMPLE_W-1:0] avg_c;

  assign hi_c        = (sample >= HI_THRESH);
  assign step_down_c = hi_c && (gain_q != GAIN_10K);
  // Accumulator is held clear outside ACCUM; in EVAL it is read before the clear lands.
  assign avg_clear_c = (state_q != ST_ACCUM);
  assign avg_add_c   = enable && (state_q == ST_ACCUM) && sample_valid && !step_down_c;

  tia_sample_averager #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk        (clk),
    .rst        (rst),
    .clear      (avg_clear_c),
    .add        (avg_add_c),
    .sample     (sample),
    .avg        (avg_c),
    .count_done (avg_done_c)
  );

  // Ranging FSM with gain, settle counter, saturation capture and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gain_q         <= GAIN_10K;
      settle_cnt_q   <= '0;
      sat_q          <= 1'b0;
      settling_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_code_q  <= '0;
      result_range_q <= '0;
      sat_flag_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (!enable) begin
        state_q      <= ST_IDLE;
        settling_q   <= 1'b0;
        settle_cnt_q <= '0;
        sat_q        <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
            settling_q   <= 1'b1;
          end
          ST_SETTLE: begin
            if (settle_cnt_q <= CNT_W'(1)) begin
              state_q      <= ST_ACCUM;
              settle_cnt_q <= '0;
              settling_q   <= 1'b0;
              sat_q        <= 1'b0;
            end else begin
              settle_cnt_q <= settle_cnt_q - CNT_W'(1);
            end
          end
          ST_ACCUM: begin
            if (sample_valid) begin
              if (step_down_c) begin
                gain_q       <= gain_q - GAIN_W'(1);
                state_q      <= ST_SETTLE;
                settle_cnt_q <= SETTLE_LOAD;
                settling_q   <= 1'b1;
              end else begin
                if (hi_c) sat_q <= 1'b1;
                if (avg_done_c) state_q <= ST_EVAL;
              end
            end
          end
          ST_EVAL: begin
            if ((avg_c < LO_THRESH) && (gain_q != GAIN_10M)) begin
              gain_q       <= gain_q + GAIN_W'(1);
              state_q      <= ST_SETTLE;
              settle_cnt_q <= SETTLE_LOAD;
              settling_q   <= 1'b1;
            end else begin
              result_valid_q <= 1'b1;
              result_code_q  <= avg_c;
              result_range_q <= gain_q;
              sat_flag_q     <= sat_q;
              sat_q          <= 1'b0;
              state_q        <= ST_ACCUM;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign gain_sel     = gain_q;
  assign settling     = settling_q;
  assign result_valid = result_valid_q;
  assign result_code  = result_code_q;
  assign result_range = result_range_q;
  assign sat_flag     = sat_flag_q;

endmodule

// File: tb/tb_tia_gain_controller.sv
// Directed bench for tia_gain_controller with default parameters
// (settle 16 cycles, 4-sample blocks, thresholds 4300/400 mV).
module tb_tia_gain_controller;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [15:0] sample;
  logic [1:0]  gain_sel;
  logic        settling;
  logic        result_valid;
  logic [15:0] result_code;
  logic [1:0]  result_range;
  logic        sat_flag;

  int checks   = 0;
  int failures = 0;
  int pulses;

  tia_gain_controller dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .gain_sel     (gain_sel),
    .settling     (settling),
    .result_valid (result_valid),
    .result_code  (result_code),
    .result_range (result_range),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    ticks(2);
    rst    = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b1;
    sample       = 16'd2000;

    // Reset state
    ticks(2);
    chk("rst_gain", 32'(gain_sel), 32'd0);
    chk("rst_settling", 32'(settling), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_code", 32'(result_code), 32'd0);
    chk("rst_range", 32'(result_range), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);

    // Constant 2000 mV: 16 settle cycles then a result every 5 cycles
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    chk("c2k_settle_first", 32'(settling), 32'd1);
    ticks(15);
    chk("c2k_settle_last", 32'(settling), 32'd1);
    tick();
    chk("c2k_settle_done", 32'(settling), 32'd0);
    ticks(4);
    chk("c2k_no_early_result", 32'(result_valid), 32'd0);
    tick();
    chk("c2k_valid1", 32'(result_valid), 32'd1);
    chk("c2k_code1", 32'(result_code), 32'd2000);
    chk("c2k_range1", 32'(result_range), 32'd0);
    chk("c2k_sat1", 32'(sat_flag), 32'd0);
    tick();
    chk("c2k_pulse_one_cycle", 32'(result_valid), 32'd0);
    chk("c2k_code_hold", 32'(result_code), 32'd2000);
    ticks(3);
    chk("c2k_gap", 32'(result_valid), 32'd0);
    tick();
    chk("c2k_valid2", 32'(result_valid), 32'd1);
    chk("c2k_code2", 32'(result_code), 32'd2000);

    // Weak signal: gain climbs 0->1->2->3, 21 cycles per step
    do_reset();
    enable = 1'b1;
    sample = 16'd100;
    ticks(21);
    chk("up_gain0_eval", 32'(gain_sel), 32'd0);
    tick();
    chk("up_gain1", 32'(gain_sel), 32'd1);
    chk("up_settle1", 32'(settling), 32'd1);
    chk("up_no_result1", 32'(result_valid), 32'd0);
    ticks(21);
    chk("up_gain2", 32'(gain_sel), 32'd2);
    ticks(21);
    chk("up_gain3", 32'(gain_sel), 32'd3);
    ticks(21);
    chk("up_valid", 32'(result_valid), 32'd1);
    chk("up_code", 32'(result_code), 32'd100);
    chk("up_range", 32'(result_range), 32'd3);
    chk("up_gain3_sat", 32'(gain_sel), 32'd3);

    // Near-saturation sample at gain 2 mid-block
    do_reset();
    enable = 1'b1;
    sample = 16'd100;
    ticks(43);
    chk("dn_gain2", 32'(gain_sel), 32'd2);
    ticks(17);
    chk("dn_in_accum", 32'(settling), 32'd0);
    sample = 16'd4400;
    tick();
    chk("dn_gain1", 32'(gain_sel), 32'd1);
    chk("dn_settling", 32'(settling), 32'd1);
    chk("dn_no_result", 32'(result_valid), 32'd0);
    sample = 16'd2000;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    chk("dn_discarded_block", 32'(pulses), 32'd0);
    tick();
    chk("dn_next_valid", 32'(result_valid), 32'd1);
    chk("dn_next_code", 32'(result_code), 32'd2000);
    chk("dn_next_range", 32'(result_range), 32'd1);

    // Saturated samples at gain 0 are averaged and flagged
    do_reset();
    enable = 1'b1;
    sample = 16'd4500;
    ticks(18);
    chk("sat_gain_stays0", 32'(gain_sel), 32'd0);
    tick();
    sample = 16'd1000;
    ticks(2);
    sample = 16'd2000;
    tick();
    chk("sat_valid", 32'(result_valid), 32'd1);
    chk("sat_code", 32'(result_code), 32'd2750);
    chk("sat_flag", 32'(sat_flag), 32'd1);
    chk("sat_range", 32'(result_range), 32'd0);
    chk("sat_gain", 32'(gain_sel), 32'd0);
    ticks(5);
    chk("sat_next_valid", 32'(result_valid), 32'd1);
    chk("sat_next_code", 32'(result_code), 32'd2000);
    chk("sat_next_flag", 32'(sat_flag), 32'd0);

    // Async reset during SETTLE at gain 3
    sample = 16'd100;
    for (int i = 0; i < 200 && gain_sel != 2'd3; i++) tick();
    chk("ar_gain3_reached", 32'(gain_sel), 32'd3);
    chk("ar_settling", 32'(settling), 32'd1);
    chk("ar_code_held", 32'(result_code), 32'd2000);
    ticks(3);
    #2 rst = 1'b1;
    #1;
    chk("ar_gain", 32'(gain_sel), 32'd0);
    chk("ar_settling_clr", 32'(settling), 32'd0);
    chk("ar_valid", 32'(result_valid), 32'd0);
    chk("ar_code", 32'(result_code), 32'd0);
    chk("ar_range", 32'(result_range), 32'd0);
    chk("ar_sat", 32'(sat_flag), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_resume_settle", 32'(settling), 32'd1);

    // Enable dropped mid-block at gain 1, then restored
    do_reset();
    enable = 1'b1;
    sample = 16'd100;
    ticks(22);
    chk("en_gain1", 32'(gain_sel), 32'd1);
    sample = 16'd2000;
    ticks(18);
    chk("en_in_accum", 32'(settling), 32'd0);
    enable = 1'b0;
    tick();
    chk("en_off_gain_held", 32'(gain_sel), 32'd1);
    chk("en_off_valid", 32'(result_valid), 32'd0);
    ticks(3);
    chk("en_idle_gain", 32'(gain_sel), 32'd1);
    chk("en_idle_settling", 32'(settling), 32'd0);
    enable = 1'b1;
    tick();
    chk("en_resettle", 32'(settling), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    chk("en_no_early_result", 32'(pulses), 32'd0);
    tick();
    chk("en_valid", 32'(result_valid), 32'd1);
    chk("en_code", 32'(result_code), 32'd2000);
    chk("en_range", 32'(result_range), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
